// File: rtl/usart_pkg.sv
// Shared definitions for the USART transmit-side byte buffer.
//   BYTE_W     : width of one transmitted byte
//   tx_state_t : hand-off FSM states (IDLE, PRESENT, WAIT_BUSY, WAIT_DONE)
package usart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESENT   = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/usart_fifo.sv
// Dual-pointer byte FIFO used by usart_tx_fifo.
//   clock, reset_n : system clock, async active-low reset
//   wr_data, wr_en : enqueue port (dropped when full or flushing)
//   rd_en          : pop strobe, ignored when empty
//   rd_data        : byte at the read pointer (combinational)
//   flush          : drop all queued bytes and clear overflow
//   full, empty    : occupancy flags
//   count          : queued bytes
//   overflow       : sticky, write attempted while full
module usart_fifo
  import usart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              flush,
  output logic [BYTE_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Flush takes priority over a same-cycle write; the byte is silently dropped.
  assign w_wr_ok = wr_en && !w_full && !flush;
  assign w_pop   = rd_en && !w_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_rptr     <= r_wptr;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)   r_rptr <= r_rptr + PTR_ONE;
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr_ok) r_mem[r_wptr] <= wr_data;
  end

  assign rd_data  = r_mem[r_rptr];
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: rtl/usart_tx_fifo.sv
// Transmit byte buffer in front of the USART transmitter.
//   clock, reset_n     : system clock, async active-low reset
//   wr_data, wr_en     : CPU-side enqueue port
//   flush              : clear queued bytes and overflow (in-flight byte kept)
//   full, empty, count : queue status (count excludes the in-flight byte)
//   overflow           : sticky, write attempted while full
//   busy               : a byte is being handed to / sent by the transmitter
//   tx_data, tx_latch  : to transmitter data_in / latch_in
//   tx_ready, tx_done  : from transmitter, asynchronous, synchronised here
module usart_tx_fifo
  import usart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              wr_en,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic              busy,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_latch,
  input  logic              tx_ready,
  input  logic              tx_done
);

  logic              r_rdy_meta;
  logic              r_rdy_s;
  logic              r_done_meta;
  logic              r_done_s;
  tx_state_t         r_state;
  logic              r_latch;
  logic              r_busy;
  logic [BYTE_W-1:0] r_data;

  logic              w_empty;
  logic              w_pop;
  logic [BYTE_W-1:0] w_rd_data;

  // done resets high: an idle transmitter reports done=1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdy_meta  <= 1'b0;
      r_rdy_s     <= 1'b0;
      r_done_meta <= 1'b1;
      r_done_s    <= 1'b1;
    end else begin
      r_rdy_meta  <= tx_ready;
      r_rdy_s     <= r_rdy_meta;
      r_done_meta <= tx_done;
      r_done_s    <= r_done_meta;
    end
  end

  // Pop exactly on the transitions into PRESENT taken by the FSM below.
  assign w_pop = !w_empty &&
                 ((r_state == ST_IDLE) || ((r_state == ST_WAIT_DONE) && r_done_s));

  usart_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_en    (w_pop),
    .flush    (flush),
    .rd_data  (w_rd_data),
    .full     (full),
    .empty    (w_empty),
    .count    (count),
    .overflow (overflow)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_data  <= w_rd_data;
            r_latch <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          // A dropped done means the frame already started; skip WAIT_BUSY.
          if (!r_done_s) begin
            r_latch <= 1'b0;
            r_state <= ST_WAIT_DONE;
          end else if (r_rdy_s) begin
            r_latch <= 1'b0;
            r_state <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (!r_done_s) r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (r_done_s) begin
            if (!w_empty) begin
              r_data  <= w_rd_data;
              r_latch <= 1'b1;
              r_state <= ST_PRESENT;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_latch <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign empty    = w_empty;
  assign busy     = r_busy;
  assign tx_data  = r_data;
  assign tx_latch = r_latch;

endmodule

// File: tb/tb_usart_tx_fifo.sv
// Directed bench for usart_tx_fifo with a simple transmitter model.
module tb_usart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    wr_data = '0;
  logic          wr_en   = 1'b0;
  logic          flush   = 1'b0;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          busy;
  logic [7:0]    tx_data;
  logic          tx_latch;
  logic          tx_ready;
  logic          tx_done;

  logic r_model_en   = 1'b0;
  logic r_model_rdy  = 1'b0;
  logic r_model_done = 1'b1;
  logic r_man_done   = 1'b1;

  assign tx_ready = r_model_rdy;
  assign tx_done  = r_model_done & r_man_done;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         gap_cnt  = 0;
  logic       gap_mon  = 1'b0;
  logic [7:0] recv[$];

  usart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_latch (tx_latch),
    .tx_ready (tx_ready),
    .tx_done  (tx_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clock);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int i;
    i = 0;
    while ((busy || !empty || !tx_done) && i < max_cycles) begin
      @(negedge clock);
      i++;
    end
    check("idle_reached", 32'(busy || !empty || !tx_done), 0);
  endtask

  // Busy dropping while bytes are still queued would be an IDLE gap.
  always @(negedge clock) begin
    if (gap_mon && !busy && !empty) gap_cnt <= gap_cnt + 1;
  end

  // Transmitter model: take the byte, pulse ready, run a 20-clock frame.
  initial begin
    int lat;
    forever begin
      @(negedge clock);
      if (r_model_en && tx_latch) begin
        recv.push_back(tx_data);
        r_model_rdy = 1'b1;
        @(negedge clock);
        r_model_rdy = 1'b0;
        lat = 1;
        while (tx_latch && lat < 8) begin
          @(negedge clock);
          lat++;
        end
        check("latch_fall_le3", 32'(lat <= 3), 1);
        r_model_done = 1'b0;
        repeat (20) @(negedge clock);
        r_model_done = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_latch", tx_latch, 0);
    check("rst_data", tx_data, 0);

    // Single byte: latch one edge after empty falls
    write_byte(8'hA5);
    check("a5_empty", empty, 0);
    check("a5_count1", count, 1);
    check("a5_latch_pre", tx_latch, 0);
    @(negedge clock);
    check("a5_latch", tx_latch, 1);
    check("a5_data", tx_data, 8'hA5);
    check("a5_count0", count, 0);
    check("a5_busy", busy, 1);
    recv.delete();
    r_model_en = 1'b1;
    wait_idle(200);
    check("a5_recv_n", recv.size(), 1);
    check("a5_recv", recv[0], 8'hA5);
    check("a5_busy_end", busy, 0);

    // Burst of 16 behind a stalled in-flight byte, plus one overflow write
    r_model_en = 1'b0;
    recv.delete();
    write_byte(8'hEE);
    @(negedge clock);
    check("bst_latch", tx_latch, 1);
    check("bst_data", tx_data, 8'hEE);
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    check("bst_full", full, 1);
    check("bst_count16", count, 16);
    check("bst_no_ovf", overflow, 0);
    write_byte(8'h55);
    check("bst_ovf", overflow, 1);
    check("bst_count_hold", count, 16);
    check("bst_full_hold", full, 1);
    gap_mon    = 1'b1;
    r_model_en = 1'b1;
    wait_idle(2000);
    gap_mon    = 1'b0;
    check("bst_recv_n", recv.size(), 17);
    check("bst_recv_first", recv[0], 8'hEE);
    for (int i = 0; i < 16; i++) check($sformatf("bst_recv_%0d", i), recv[i+1], i);
    check("bst_gap", gap_cnt, 0);

    // Write and pop on the same edge at count=3
    r_model_en = 1'b0;
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    write_byte(8'h34);
    check("wp_count3", count, 3);
    check("wp_data31", tx_data, 8'h31);
    r_man_done = 1'b0;
    repeat (4) @(negedge clock);
    check("wp_latch_drop", tx_latch, 0);
    check("wp_busy", busy, 1);
    r_man_done = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("wp_pre_latch", tx_latch, 0);
    check("wp_pre_count", count, 3);
    wr_data = 8'h35;
    wr_en   = 1'b1;
    @(negedge clock);
    wr_en   = 1'b0;
    check("wp_count_same", count, 3);
    check("wp_latch", tx_latch, 1);
    check("wp_data32", tx_data, 8'h32);

    // Flush with 5 queued while 0x32 is in flight; flush beats a same-cycle write
    write_byte(8'h36);
    write_byte(8'h37);
    check("fl_count5", count, 5);
    check("fl_ovf_sticky", overflow, 1);
    flush   = 1'b1;
    wr_data = 8'h99;
    wr_en   = 1'b1;
    @(negedge clock);
    flush   = 1'b0;
    wr_en   = 1'b0;
    check("fl_count0", count, 0);
    check("fl_empty", empty, 1);
    check("fl_ovf_clr", overflow, 0);
    check("fl_busy", busy, 1);
    check("fl_inflight", tx_data, 8'h32);
    recv.delete();
    r_model_en = 1'b1;
    wait_idle(300);
    check("fl_recv_n", recv.size(), 1);
    check("fl_recv", recv[0], 8'h32);
    check("fl_idle_count", count, 0);

    // Reset mid-PRESENT
    r_model_en = 1'b0;
    write_byte(8'h77);
    write_byte(8'h78);
    check("rm_latch", tx_latch, 1);
    check("rm_data", tx_data, 8'h77);
    check("rm_count", count, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rm_async_latch", tx_latch, 0);
    check("rm_async_busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);
    check("rm_empty", empty, 1);
    check("rm_count0", count, 0);
    check("rm_no_latch", tx_latch, 0);
    check("rm_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
